// File: rtl/difftest_commit_sequencer.sv
// -----------------------------------------------------------------------------
// difftest_commit_sequencer
//
// Takes retire groups of up to two instructions per cycle (lane 0 older than
// lane 1) and feeds them one record per cycle, in retire order, to a
// single-record difftest commit port. An 8-entry FIFO sits between the two
// sides.
//
// Ports
//   clock                   : single clock, everything updates on its rising edge
//   reset                   : synchronous, active-high reset
//   in_valid0 / in_valid1   : retire-lane valids (lane 0 older)
//   in0_* / in1_*           : per-lane record (pc 64, instr 32, wdest 8,
//                             flags 5 = {skip, isRVC, rfwen, isLoad, isStore})
//   in_ready                : room for a full two-lane group this cycle
//   out_valid               : a commit record is being presented
//   out_pc/instr/wdest/flags: the presented record (held while out_valid = 0)
//   out_seq                 : 8-bit commit sequence number of the record
//   count                   : FIFO occupancy, 0..8
//   commit_cnt              : records presented since reset, wraps at 2^64
//   err_lane                : sticky protocol-error flag
// -----------------------------------------------------------------------------
module difftest_commit_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid0,
   input  logic        in_valid1,
   input  logic [63:0] in0_pc,
   input  logic [63:0] in1_pc,
   input  logic [31:0] in0_instr,
   input  logic [31:0] in1_instr,
   input  logic [7:0]  in0_wdest,
   input  logic [7:0]  in1_wdest,
   input  logic [4:0]  in0_flags,
   input  logic [4:0]  in1_flags,
   output logic        in_ready,
   output logic        out_valid,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   output logic [7:0]  out_wdest,
   output logic [4:0]  out_flags,
   output logic [7:0]  out_seq,
   output logic [3:0]  count,
   output logic [63:0] commit_cnt,
   output logic        err_lane
);

   logic [63:0] pc_mem    [8];
   logic [31:0] instr_mem [8];
   logic [7:0]  wdest_mem [8];
   logic [4:0]  flags_mem [8];

   logic [2:0] wr_ptr;
   logic [2:0] rd_ptr;
   logic [2:0] wr_ptr_p1;

   logic       push0;
   logic       push1;
   logic [3:0] num_push;
   logic [3:0] free_slots;
   logic       overflow;
   logic       acc0;
   logic       acc1;
   logic       pop;
   logic       lane_err;

   // Accept/pop decisions. in_ready looks only at the registered occupancy so
   // it never depends combinationally on the lane valids. Lane 1 is only
   // legal alongside lane 0; a lone lane 1 is dropped and flagged, whether or
   // not the queue has room, since it is an upstream protocol violation either
   // way. The overflow guard cannot trip while in_ready gates pushes, but if it
   // ever did the whole group is discarded rather than corrupting the FIFO.
   always_comb begin
      in_ready   = (count <= 4'd6);
      push0      = in_ready & in_valid0;
      push1      = in_ready & in_valid0 & in_valid1;
      num_push   = {3'b000, push0} + {3'b000, push1};
      free_slots = 4'd8 - count;
      overflow   = (num_push > free_slots);
      acc0       = push0 & ~overflow;
      acc1       = push1 & ~overflow;
      pop        = (count != 4'd0);
      lane_err   = in_valid1 & ~in_valid0;
      wr_ptr_p1  = wr_ptr + 3'd1;
   end

   // FIFO storage. Lane 0 lands at the write pointer and lane 1 in the slot
   // right after it, which keeps acceptance order in the ring. Pushes only
   // happen with at least two free slots, so neither write can hit the entry
   // being read out on the same edge. Contents need no reset because the
   // pointers and count decide what is valid; writes are still suppressed on
   // reset edges so lane data sampled there is truly ignored.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (acc0) begin
            pc_mem[wr_ptr]    <= in0_pc;
            instr_mem[wr_ptr] <= in0_instr;
            wdest_mem[wr_ptr] <= in0_wdest;
            flags_mem[wr_ptr] <= in0_flags;
         end
         if (acc1) begin
            pc_mem[wr_ptr_p1]    <= in1_pc;
            instr_mem[wr_ptr_p1] <= in1_instr;
            wdest_mem[wr_ptr_p1] <= in1_wdest;
            flags_mem[wr_ptr_p1] <= in1_flags;
         end
      end
   end

   // Pointers, occupancy and the registered output record. The head is popped
   // every cycle the queue holds something; there is no backpressure from the
   // commit port. The sequence number is the low byte of the commit counter
   // before it increments, so the first record after reset carries 0 and the
   // number wraps 255 -> 0 for free. Output data holds when nothing pops.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= 3'd0;
         rd_ptr     <= 3'd0;
         count      <= 4'd0;
         out_valid  <= 1'b0;
         out_pc     <= 64'd0;
         out_instr  <= 32'd0;
         out_wdest  <= 8'd0;
         out_flags  <= 5'd0;
         out_seq    <= 8'd0;
         commit_cnt <= 64'd0;
         err_lane   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + {2'b00, acc0} + {2'b00, acc1};
         rd_ptr <= rd_ptr + {2'b00, pop};
         count  <= count + {3'b000, acc0} + {3'b000, acc1} - {3'b000, pop};
         if (pop) begin
            out_valid  <= 1'b1;
            out_pc     <= pc_mem[rd_ptr];
            out_instr  <= instr_mem[rd_ptr];
            out_wdest  <= wdest_mem[rd_ptr];
            out_flags  <= flags_mem[rd_ptr];
            out_seq    <= commit_cnt[7:0];
            commit_cnt <= commit_cnt + 64'd1;
         end else begin
            out_valid <= 1'b0;
         end
         if (lane_err || overflow) begin
            err_lane <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_difftest_commit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_difftest_commit_sequencer
//
// Directed bench for difftest_commit_sequencer. Every accepted lane record is
// pushed onto a scoreboard queue as it is driven; each cycle the bench's own
// occupancy model decides whether a record should pop, and the popped entry
// is compared against the DUT's registered output after the edge.
// -----------------------------------------------------------------------------
module tb_difftest_commit_sequencer;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [7:0]  wdest;
      logic [4:0]  flags;
   } rec_t;

   logic        clock;
   logic        reset;
   logic        in_valid0;
   logic        in_valid1;
   logic [63:0] in0_pc;
   logic [63:0] in1_pc;
   logic [31:0] in0_instr;
   logic [31:0] in1_instr;
   logic [7:0]  in0_wdest;
   logic [7:0]  in1_wdest;
   logic [4:0]  in0_flags;
   logic [4:0]  in1_flags;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic [7:0]  out_wdest;
   logic [4:0]  out_flags;
   logic [7:0]  out_seq;
   logic [3:0]  count;
   logic [63:0] commit_cnt;
   logic        err_lane;

   rec_t        sb [$];
   logic        m_valid;
   rec_t        m_out;
   logic [7:0]  m_seq;
   logic [63:0] m_commit;
   logic        m_err;

   int checks = 0;
   int errors = 0;

   difftest_commit_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid0  (in_valid0),
      .in_valid1  (in_valid1),
      .in0_pc     (in0_pc),
      .in1_pc     (in1_pc),
      .in0_instr  (in0_instr),
      .in1_instr  (in1_instr),
      .in0_wdest  (in0_wdest),
      .in1_wdest  (in1_wdest),
      .in0_flags  (in0_flags),
      .in1_flags  (in1_flags),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_pc     (out_pc),
      .out_instr  (out_instr),
      .out_wdest  (out_wdest),
      .out_flags  (out_flags),
      .out_seq    (out_seq),
      .count      (count),
      .commit_cnt (commit_cnt),
      .err_lane   (err_lane)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Builds a full record from a pc so every field varies with the pc,
   // including the skip flag in bit 4.
   function automatic rec_t mk_rec(input logic [63:0] pc);
      rec_t r;
      r.pc    = pc;
      r.instr = pc[31:0] ^ 32'h0000_0013;
      r.wdest = pc[9:2];
      r.flags = pc[6:2] ^ pc[11:7];
      return r;
   endfunction

   // One comparison: counts it, and on mismatch counts the failure and reports.
   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compares every DUT output against the model state.
   task automatic check_all();
      check_output("in_ready",   {63'd0, in_ready},  {63'd0, (sb.size() <= 6)});
      check_output("count",      {60'd0, count},     64'(sb.size()));
      check_output("out_valid",  {63'd0, out_valid}, {63'd0, m_valid});
      check_output("out_pc",     out_pc,             m_out.pc);
      check_output("out_instr",  {32'd0, out_instr}, {32'd0, m_out.instr});
      check_output("out_wdest",  {56'd0, out_wdest}, {56'd0, m_out.wdest});
      check_output("out_flags",  {59'd0, out_flags}, {59'd0, m_out.flags});
      check_output("out_seq",    {56'd0, out_seq},   {56'd0, m_seq});
      check_output("commit_cnt", commit_cnt,         m_commit);
      check_output("err_lane",   {63'd0, err_lane},  {63'd0, m_err});
   endtask

   // Drives one cycle of inputs, advances the model across the edge and checks
   // the DUT 1 time unit after the edge. The pop uses the pre-edge queue, then
   // accepted lanes are appended in lane order.
   task automatic apply_stimulus(input logic r, input logic v0, input logic v1,
                                 input logic [63:0] pc0, input logic [63:0] pc1);
      rec_t r0;
      rec_t r1;
      bit   ready;
      r0 = mk_rec(pc0);
      r1 = mk_rec(pc1);
      reset     = r;
      in_valid0 = v0;
      in_valid1 = v1;
      in0_pc    = r0.pc;
      in0_instr = r0.instr;
      in0_wdest = r0.wdest;
      in0_flags = r0.flags;
      in1_pc    = r1.pc;
      in1_instr = r1.instr;
      in1_wdest = r1.wdest;
      in1_flags = r1.flags;
      @(posedge clock);
      if (r) begin
         sb.delete();
         m_valid  = 1'b0;
         m_out    = '0;
         m_seq    = 8'd0;
         m_commit = 64'd0;
         m_err    = 1'b0;
      end else begin
         ready = (sb.size() <= 6);
         if (sb.size() > 0) begin
            m_out    = sb.pop_front();
            m_valid  = 1'b1;
            m_seq    = m_commit[7:0];
            m_commit = m_commit + 64'd1;
         end else begin
            m_valid = 1'b0;
         end
         if (ready && v0) sb.push_back(r0);
         if (ready && v0 && v1) sb.push_back(r1);
         if (v1 && !v0) m_err = 1'b1;
      end
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      in0_pc    = '0;
      in1_pc    = '0;
      in0_instr = '0;
      in1_instr = '0;
      in0_wdest = '0;
      in1_wdest = '0;
      in0_flags = '0;
      in1_flags = '0;
      m_valid   = 1'b0;
      m_out     = '0;
      m_seq     = 8'd0;
      m_commit  = 64'd0;
      m_err     = 1'b0;

      $display("[TB] reset state");
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      check_output("reset_in_ready", {63'd0, in_ready}, 64'd1);

      $display("[TB] single lane");
      apply_stimulus(1'b0, 1'b1, 1'b0, 64'h8000_0000, 64'd0);
      idle(3);

      $display("[TB] dual lane");
      apply_stimulus(1'b0, 1'b1, 1'b1, 64'h8000_0000, 64'h8000_0004);
      idle(4);

      $display("[TB] fill until not ready");
      for (int i = 0; i < 20 && sb.size() <= 6; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1, 64'h1000 + 64'(16 * i), 64'h1008 + 64'(16 * i));
      end
      check_output("fill_count", {60'd0, count}, 64'd7);
      check_output("fill_not_ready", {63'd0, in_ready}, 64'd0);
      idle(10);
      check_output("drain_count", {60'd0, count}, 64'd0);

      $display("[TB] lane 1 without lane 0");
      apply_stimulus(1'b0, 1'b0, 1'b1, 64'd0, 64'h2000);
      check_output("lane_err_set", {63'd0, err_lane}, 64'd1);
      idle(2);
      apply_stimulus(1'b0, 1'b1, 1'b0, 64'h3000, 64'd0);
      idle(3);
      check_output("lane_err_sticky", {63'd0, err_lane}, 64'd1);

      $display("[TB] sequence wrap");
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b0, 64'h8000_0000 + 64'(4 * i), 64'd0);
      end
      idle(3);
      check_output("wrap_commit_cnt", commit_cnt, 64'd300);
      check_output("wrap_last_seq", {56'd0, out_seq}, 64'd43);

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1, 64'h4000 + 64'(16 * i), 64'h4008 + 64'(16 * i));
      end
      check_output("midreset_count5", {60'd0, count}, 64'd5);
      apply_stimulus(1'b1, 1'b1, 1'b1, 64'h5000, 64'h5008);
      check_output("midreset_ready", {63'd0, in_ready}, 64'd1);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
